// File: rtl/seq_tx.sv
// seq_tx: parallel-to-serial pattern transmitter with a run-reference flag.
//
// Accepts WIDTH-bit words over a valid/ready handshake and shifts them out
// MSB-first, one bit per clock. Back-to-back words stream with no gap. The
// Mealy flag run_hit marks every bit that completes a run of RUN_LEN (or more)
// consecutive equal bits; the flag is the golden reference for the run/sequence
// detectors fed by x.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   din        word to transmit
//   din_valid  din is presented
//   din_ready  word can be accepted this cycle (IDLE, or last bit of a word)
//   x          serial data bit (MSB first)
//   x_valid    x carries a transmitted bit
//   run_hit    current x completes a run of >= RUN_LEN equal bits
//   busy       a word is in flight (same as x_valid)
module seq_tx #(
  parameter int WIDTH   = 8,
  parameter int RUN_LEN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             run_hit,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Wide enough to hold eff, which can reach RUN_LEN before saturation.
  localparam int HW = $clog2(RUN_LEN + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             hist_bit_q, hist_bit_d;
  logic [HW-1:0]    hist_cnt_q, hist_cnt_d;

  logic             last_bit;
  logic [HW-1:0]    eff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      hist_bit_q <= 1'b0;
      hist_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      hist_bit_q <= hist_bit_d;
      hist_cnt_q <= hist_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    hist_bit_d = hist_bit_q;
    hist_cnt_d = hist_cnt_q;

    last_bit  = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
    x_valid   = (state_q == SHIFT);
    busy      = x_valid;
    x         = x_valid & shift_q[WIDTH-1];
    // Ready on the last bit lets the next word follow with no idle cycle.
    din_ready = (state_q == IDLE) || last_bit;

    case (state_q)
      IDLE: begin
        if (din_valid) begin
          shift_d = din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + 1'b1;
        if (last_bit) begin
          cnt_d = '0;
          if (din_valid) shift_d = din;
          else           state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Run tracking: eff is the run length including the current bit.
    if ((hist_cnt_q != '0) && (x == hist_bit_q)) eff = hist_cnt_q + 1'b1;
    else                                         eff = HW'(1);
    run_hit = x_valid && (eff >= HW'(RUN_LEN));

    if (x_valid) begin
      hist_bit_d = x;
      // Saturate one below RUN_LEN so every further equal bit re-fires.
      hist_cnt_d = (eff >= HW'(RUN_LEN)) ? HW'(RUN_LEN - 1) : eff;
    end else begin
      // An idle cycle breaks any run in progress.
      hist_cnt_d = '0;
    end
  end

endmodule

// File: doc/seq_tx.md
Name: seq_tx

Overview:
- Parallel-to-serial pattern transmitter that drives the single-bit stream consumed by the team's run/sequence detectors.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clock.
- Emits a Mealy reference flag, run_hit, that marks every bit completing RUN_LEN consecutive equal bits (000/111 with defaults). Overlaps are allowed.
- Used as a stimulus source and as the golden model for detector checking.

Parameters:
- WIDTH, 8, bits per word, must be >= 2.
- RUN_LEN, 3, run length that asserts run_hit, must be >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- din  input  WIDTH  word to transmit.
- din_valid  input  1  din is presented.
- din_ready  output  1  block can accept din this cycle.
- x  output  1  serial data bit.
- x_valid  output  1  x carries a transmitted bit this cycle.
- run_hit  output  1  current x completes a run of >= RUN_LEN equal bits.
- busy  output  1  a word is in flight (same as x_valid).

Behaviour:
- Reset:
  - One clock domain. Reset is asynchronous and active-low on rst.
  - While rst=0: state=IDLE, shift register=0, bit counter=0, run history count=0, history bit=0.
  - Outputs during reset: x=0, x_valid=0, busy=0, run_hit=0, din_ready=1. Inputs are ignored; no word is captured.
- State machine:
  - IDLE: din_ready=1, x_valid=0. A clock edge with din_valid=1 captures din into the shift register, clears the bit counter to 0, and moves to SHIFT.
  - SHIFT: x_valid=1, x = shift register MSB. Each edge shifts left by one and increments the bit counter.
  - When bit_cnt = WIDTH-1 (last bit), din_ready=1. If din_valid=1 at that edge, the new word is loaded, the FSM stays in SHIFT, and the next cycle carries bit 1 of the new word with no gap. Otherwise the FSM returns to IDLE.
  - During SHIFT with bit_cnt < WIDTH-1, din_ready=0 and din_valid is ignored. No word is dropped or overwritten.
- Latency:
  - Word accepted at edge N puts its MSB on x in the cycle after edge N.
  - Word k bit i (0 = MSB) appears i cycles after that.
- Run tracking:
  - Registered state: hist_bit and hist_cnt, where hist_cnt ranges 0..RUN_LEN-1 and saturates.
  - eff = hist_cnt+1 if hist_cnt>0 and x==hist_bit, else 1.
  - run_hit = x_valid and (eff >= RUN_LEN). This is combinational (Mealy).
  - On an edge with x_valid=1: hist_bit<=x and hist_cnt<=min(eff, RUN_LEN-1). Saturation keeps the flag high on every further equal bit.
  - On an edge with x_valid=0: hist_cnt<=0. An idle gap breaks runs.
  - Runs span word boundaries when words are back-to-back.
- Reset mid-word: transmission aborts immediately (x_valid=0 asynchronously) and the partial word is discarded. Run history is cleared.
- Simultaneous din_valid and reset release: capture happens only on an edge where rst=1.

Test Plan:
1. Single word 8'b1110_0011 accepted from IDLE -> x = 1,1,1,0,0,0,1,1 on 8 consecutive cycles starting one cycle after accept. run_hit=1 only on bits 3 and 6. x_valid returns to 0 on cycle 9.
2. Word 8'hFF -> run_hit=0 on bits 1 and 2, then 1 on bits 3 through 8 (6 cycles), confirming overlap and saturation.
3. Back-to-back 8'h01 then 8'h80, with the second word's din_valid held from the start -> din_ready=0 on bits 1–7 and 1 on bit 8. Result is 16 contiguous x_valid cycles: 0×7, 1, 1, 0×7. run_hit on stream bits 3–7 and 12–16 only; none on bits 8–11.
4. Words 8'h03 and 8'hE0 with one idle cycle between -> second word's first three bits 1,1,1 give run_hit only on its third bit. Repeating with no gap -> run_hit on its first bit, since the run continues from the trailing 1,1.
5. Assert rst=0 after 4 bits of 8'hAA -> x_valid, busy and run_hit drop immediately. After release, din_ready=1. Next word 8'h00 gives run_hit starting at its bit 3; no history carries over.
6. din_valid=0 throughout after reset -> x_valid=0, run_hit=0, din_ready=1 indefinitely.
